redxor_signature_accum: RTL and testbench

//  - Streaming consumer of 128-bit words on a valid/ready channel, framed into bursts by in_last.
//  - Per word: XOR-reduces each LANE_W-bit lane to one parity bit (unsigned, zero-extended lanes).
//  - XOR-accumulates the lane parities into a per-burst signature and emits it with a word count.
//  - Sits downstream of the unary-XOR reduction cosim stages; gives the bench one compact check per burst.

---
 rtl/redxor_pkg.sv | 27 ++
 rtl/redxor_signature_accum_if.sv | 36 +++
 rtl/redxor_lane_reduce.sv | 21 ++
 rtl/redxor_signature_accum.sv | 132 +++++++++++++
 tb/tb_redxor_signature_accum.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/redxor_pkg.sv
// Package: redxor_pkg
// Purpose : Shared defaults, the lane-count helper and the default-width result record for the
//           redxor_signature_accum block.
// Contents:
//   IN_W, LANE_W, CNT_W - default word width, lane width and burst counter width
//   NLANES              - default number of lanes (= signature bits)
//   lane_count()        - number of LANE_W-bit lanes in an IN_W-bit word
//   redxor_result_t     - {sig, count, ovf} at the default widths
package redxor_pkg;

    localparam int unsigned IN_W   = 128;
    localparam int unsigned LANE_W = 8;
    localparam int unsigned CNT_W  = 16;

    function automatic int unsigned lane_count(input int unsigned in_w, input int unsigned lane_w);
        return in_w / lane_w;
    endfunction

    localparam int unsigned NLANES = lane_count(IN_W, LANE_W);

    typedef struct packed {
        logic [NLANES-1:0] sig;
        logic [CNT_W-1:0]  count;
        logic              ovf;
    } redxor_result_t;

endpackage

// File: rtl/redxor_signature_accum_if.sv
// Interface: redxor_signature_accum_if
// Purpose  : Input word channel and burst-result channel of redxor_signature_accum.
// Signals  :
//   in_valid/in_ready/in_data/in_last                       - word stream (producer -> block)
//   out_valid/out_ready/out_sig/out_parity/out_count/out_ovf - burst result (block -> consumer)
// Modports : master = producer/consumer side (testbench), slave = the accumulator block.
interface redxor_signature_accum_if
#(
    parameter int unsigned IN_W   = redxor_pkg::IN_W,
    parameter int unsigned NLANES = redxor_pkg::NLANES,
    parameter int unsigned CNT_W  = redxor_pkg::CNT_W
);

    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic              in_last;

    logic              out_valid;
    logic              out_ready;
    logic [NLANES-1:0] out_sig;
    logic              out_parity;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sig, out_parity, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sig, out_parity, out_count, out_ovf
    );

endinterface

// File: rtl/redxor_lane_reduce.sv
// Module : redxor_lane_reduce
// Purpose: Combinational unary-XOR of each LANE_W-bit lane of a word to one parity bit.
// Ports  :
//   i_data [IN_W]   - input word; lane k = i_data[k*LANE_W +: LANE_W]
//   o_par  [NLANES] - o_par[k] = ^lane k
module redxor_lane_reduce
    import redxor_pkg::*;
#(
    parameter int unsigned IN_W   = redxor_pkg::IN_W,
    parameter int unsigned LANE_W = redxor_pkg::LANE_W,
    localparam int unsigned NLANES = redxor_pkg::lane_count(IN_W, LANE_W)
) (
    input  logic [IN_W-1:0]   i_data,
    output logic [NLANES-1:0] o_par
);

    for (genvar k = 0; k < NLANES; k++) begin : g_lane
        assign o_par[k] = ^i_data[k*LANE_W +: LANE_W];
    end

endmodule

// File: rtl/redxor_signature_accum.sv
// Module : redxor_signature_accum
// Purpose: Per accepted word, reduce every lane to a parity bit, XOR-accumulate those parities
//          over a burst (framed by in_last) and present the burst signature, its overall parity,
//          a saturating word count and an overflow flag on a valid/ready result channel.
// Ports  :
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset (deassert synchronously to clk)
//   io_bus - slave side of redxor_signature_accum_if (word stream in, burst result out)
// Pipeline: S1 register (lane parities + last) -> accumulators -> result register.
//           State is carried by the valid bits only.
module redxor_signature_accum
    import redxor_pkg::*;
#(
    parameter int unsigned IN_W   = redxor_pkg::IN_W,
    parameter int unsigned LANE_W = redxor_pkg::LANE_W,
    parameter int unsigned CNT_W  = redxor_pkg::CNT_W,
    localparam int unsigned NLANES = redxor_pkg::lane_count(IN_W, LANE_W)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    redxor_signature_accum_if.slave  io_bus
);

    // Same layout as redxor_result_t, sized by this instance's parameters.
    typedef struct packed {
        logic [NLANES-1:0] sig;
        logic [CNT_W-1:0]  count;
        logic              ovf;
    } result_t;

    logic [NLANES-1:0] w_lane_par;

    logic              r_s1_valid;
    logic              r_s1_last;
    logic [NLANES-1:0] r_s1_par;

    logic [NLANES-1:0] r_acc_sig;
    logic [CNT_W-1:0]  r_acc_cnt;
    logic              r_acc_ovf;

    result_t           r_res;
    logic              r_out_valid;

    logic              w_s1_adv;
    logic              w_in_ready;
    logic              w_in_fire;
    logic              w_res_load;
    logic              w_cnt_max;
    logic [NLANES-1:0] w_sig_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_ovf_next;

    redxor_lane_reduce #(
        .IN_W   (IN_W),
        .LANE_W (LANE_W)
    ) u_lane_reduce (
        .i_data (io_bus.in_data),
        .o_par  (w_lane_par)
    );

    always_comb begin
        // Only a completing word has to wait for room in the result register.
        w_s1_adv   = r_s1_valid & ~(r_s1_last & r_out_valid & ~io_bus.out_ready);
        // Gated by rst_n so the channel reads not-ready for the whole reset.
        w_in_ready = rst_n & (~r_s1_valid | w_s1_adv);
        w_in_fire  = io_bus.in_valid & w_in_ready;
        w_res_load = w_s1_adv & r_s1_last;

        w_cnt_max  = &r_acc_cnt;
        w_sig_next = r_acc_sig ^ r_s1_par;
        w_cnt_next = w_cnt_max ? r_acc_cnt : r_acc_cnt + CNT_W'(1);
        // Overflow once a word arrives while the count already sits at all-ones.
        w_ovf_next = r_acc_ovf | w_cnt_max;
    end

    // S1: lane parities of the accepted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_par   <= '0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_last  <= io_bus.in_last;
            r_s1_par   <= w_lane_par;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Accumulators restart from zero on the same edge a burst is stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_sig <= '0;
            r_acc_cnt <= '0;
            r_acc_ovf <= 1'b0;
        end else if (w_s1_adv) begin
            if (r_s1_last) begin
                r_acc_sig <= '0;
                r_acc_cnt <= '0;
                r_acc_ovf <= 1'b0;
            end else begin
                r_acc_sig <= w_sig_next;
                r_acc_cnt <= w_cnt_next;
                r_acc_ovf <= w_ovf_next;
            end
        end
    end

    // Result register: a load only happens when it is empty or being consumed this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res       <= '0;
            r_out_valid <= 1'b0;
        end else if (w_res_load) begin
            r_res.sig   <= w_sig_next;
            r_res.count <= w_cnt_next;
            r_res.ovf   <= w_ovf_next;
            r_out_valid <= 1'b1;
        end else if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign io_bus.in_ready   = w_in_ready;
    assign io_bus.out_valid  = r_out_valid;
    assign io_bus.out_sig    = r_res.sig;
    assign io_bus.out_parity = ^r_res.sig;
    assign io_bus.out_count  = r_res.count;
    assign io_bus.out_ovf    = r_res.ovf;

endmodule

// File: tb/tb_redxor_signature_accum.sv
// Testbench: tb_redxor_signature_accum
// Purpose  : Directed, table-driven check of redxor_signature_accum (CNT_W = 4 so the counter
//            saturates within a short burst) plus hand-written latency, back-to-back,
//            backpressure, saturation and mid-burst reset sequences.
module tb_redxor_signature_accum;

    localparam int unsigned TbInW   = 128;
    localparam int unsigned TbLaneW = 8;
    localparam int unsigned TbNl    = 16;
    localparam int unsigned TbCntW  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    redxor_signature_accum_if #(
        .IN_W   (TbInW),
        .NLANES (TbNl),
        .CNT_W  (TbCntW)
    ) bus ();

    redxor_signature_accum #(
        .IN_W   (TbInW),
        .LANE_W (TbLaneW),
        .CNT_W  (TbCntW)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [15:0] sig;
        logic        par;
        logic [3:0]  cnt;
        logic        ovf;
    } res_t;

    res_t res_q[$];

    // Records every result handed over to the consumer.
    always @(posedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            res_q.push_back({bus.out_sig, bus.out_parity, bus.out_count, bus.out_ovf});
        end
    end

    typedef struct {
        logic [127:0] data;
        logic         last;
        logic [15:0]  sig;
        logic         par;
        logic [3:0]   cnt;
        logic         ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [127:0] d, input logic l);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready got 0 for 50 cycles, expected 1");
        end else begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 'x;
        bus.in_last  = 1'b0;
    endtask

    task automatic expect_res(input string name, input logic [15:0] sig, input logic par,
                              input logic [3:0] cnt, input logic ovf);
        res_t r;
        int   n = 0;
        while (res_q.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (res_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no result in 100 cycles, expected one", name);
        end else begin
            r = res_q.pop_front();
            check({name, ".sig"}, 32'(r.sig), 32'(sig));
            check({name, ".parity"}, 32'(r.par), 32'(par));
            check({name, ".count"}, 32'(r.cnt), 32'(cnt));
            check({name, ".ovf"}, 32'(r.ovf), 32'(ovf));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation got no finish, expected one before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{128'h3, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0};
        vecs[1] = '{128'h1, 1'b1, 16'h0001, 1'b1, 4'd2, 1'b0};
        vecs[2] = '{{128{1'b1}}, 1'b1, 16'h0000, 1'b0, 4'd1, 1'b0};
        vecs[3] = '{{16{8'h01}}, 1'b1, 16'hFFFF, 1'b0, 4'd1, 1'b0};
        vecs[4] = '{128'h7, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0};
        vecs[5] = '{128'h300, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0};
        vecs[6] = '{128'h0100_0000_0000_0000_0000_0000_0000_0000, 1'b1,
                    16'h8001, 1'b0, 4'd3, 1'b0};
        vecs[7] = '{128'hFE_0000, 1'b1, 16'h0004, 1'b1, 4'd1, 1'b0};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst.in_ready", 32'(bus.in_ready), 32'd0);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.out_sig", 32'(bus.out_sig), 32'd0);
        check("rst.out_count", 32'(bus.out_count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel.in_ready", 32'(bus.in_ready), 32'd1);

        // Single-word burst: result appears two edges after the word is presented
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 128'h1;
        bus.in_last   = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 'x;
        bus.in_last  = 1'b0;
        @(negedge clk);
        check("lat.early_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("lat.valid", 32'(bus.out_valid), 32'd1);
        expect_res("single", 16'h0001, 1'b1, 4'd1, 1'b0);

        // Table-driven bursts
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].data, vecs[i].last);
            if (vecs[i].last) begin
                expect_res($sformatf("vec%0d", i), vecs[i].sig, vecs[i].par,
                           vecs[i].cnt, vecs[i].ovf);
            end
        end

        // Back-to-back single-word bursts with no backpressure
        send(128'h1, 1'b1);
        send(128'h100, 1'b1);
        send(128'h3, 1'b0);
        send(128'h10000, 1'b1);
        expect_res("b2b0", 16'h0001, 1'b1, 4'd1, 1'b0);
        expect_res("b2b1", 16'h0002, 1'b1, 4'd1, 1'b0);
        expect_res("b2b2", 16'h0004, 1'b1, 4'd2, 1'b0);

        // Backpressure: second completing word stalls in S1 while the first result is held
        repeat (2) @(negedge clk);
        bus.out_ready = 1'b0;
        send(128'h1, 1'b1);
        send(128'h100, 1'b1);
        @(negedge clk);
        check("bp.in_ready", 32'(bus.in_ready), 32'd0);
        check("bp.out_valid", 32'(bus.out_valid), 32'd1);
        check("bp.sig", 32'(bus.out_sig), 32'h0001);
        repeat (3) @(negedge clk);
        check("bp.sig_held", 32'(bus.out_sig), 32'h0001);
        check("bp.in_ready_held", 32'(bus.in_ready), 32'd0);
        check("bp.none_taken", 32'(res_q.size()), 32'd0);
        bus.out_ready = 1'b1;
        expect_res("bp0", 16'h0001, 1'b1, 4'd1, 1'b0);
        expect_res("bp1", 16'h0002, 1'b1, 4'd1, 1'b0);

        // Counter saturation boundaries (CNT_W = 4)
        for (int i = 0; i < 15; i++) send('0, i == 14);
        expect_res("sat15", 16'h0000, 1'b0, 4'hF, 1'b0);
        for (int i = 0; i < 16; i++) send('0, i == 15);
        expect_res("sat16", 16'h0000, 1'b0, 4'hF, 1'b1);
        for (int i = 0; i < 17; i++) send('0, i == 16);
        expect_res("sat17", 16'h0000, 1'b0, 4'hF, 1'b1);
        send(128'h1, 1'b1);
        expect_res("sat_after", 16'h0001, 1'b1, 4'd1, 1'b0);

        // Reset mid-burst with a pending result; non-last words still flow while it is held
        bus.out_ready = 1'b0;
        send(128'h1, 1'b1);
        for (int i = 0; i < 3; i++) send(128'h1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst.in_ready", 32'(bus.in_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        res_q.delete();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(128'h1, 1'b1);
        expect_res("post_rst", 16'h0001, 1'b1, 4'd1, 1'b0);
        repeat (3) @(negedge clk);
        check("post_rst.no_extra", 32'(res_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
